traffic_light_ctrl: RTL

//  Two-road (NS/EW) traffic-light sequencer. A six-phase FSM is timed by a 7-bit clear/count phase timer.

---
 rtl/traffic_light_ctrl_pkg.sv | 53 +++++
 rtl/traffic_light_ctrl_phase_timer.sv | 33 +++
 rtl/traffic_light_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/traffic_light_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl_pkg
//   Shared definitions for the intersection design: phase state encodings,
//   lamp codes and lamp decode helpers. This package is also used by the
//   display and monitor blocks, so the encodings here are the single source
//   of truth.
//   Contents:
//     phase_e          NS_G=0, NS_Y=1, AR1=2, EW_G=3, EW_Y=4, AR2=5
//     LAMP_R/Y/G       {R,Y,G} one-hot lamp codes
//     ns_lamp/ew_lamp  lamp pattern for each road in a given phase
//     is_allred        1 when the phase is one of the all-red phases
// ----------------------------------------------------------------------------
package traffic_light_ctrl_pkg;

   typedef enum logic [2:0] {
      NS_G = 3'd0,
      NS_Y = 3'd1,
      AR1  = 3'd2,
      EW_G = 3'd3,
      EW_Y = 3'd4,
      AR2  = 3'd5
   } phase_e;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   // Illegal encodings show red on both roads.
   function automatic logic [2:0] ns_lamp(input phase_e ph);
      case (ph)
         NS_G:    ns_lamp = LAMP_G;
         NS_Y:    ns_lamp = LAMP_Y;
         default: ns_lamp = LAMP_R;
      endcase
   endfunction

   function automatic logic [2:0] ew_lamp(input phase_e ph);
      case (ph)
         EW_G:    ew_lamp = LAMP_G;
         EW_Y:    ew_lamp = LAMP_Y;
         default: ew_lamp = LAMP_R;
      endcase
   endfunction

   function automatic logic is_allred(input phase_e ph);
      case (ph)
         AR1:     is_allred = 1'b1;
         AR2:     is_allred = 1'b1;
         default: is_allred = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
//   7-bit synchronous up-counter timing the current traffic phase.
//   Ports:
//     Clk    in   system clock, rising edge
//     Clear  in   synchronous clear to 0, priority over Count
//     Count  in   increment enable
//     Q      out  current count [6:0]
//   Phase limits never exceed 127, so the count is cleared before it can wrap.
// ----------------------------------------------------------------------------
module phase_timer (
   input  logic       Clk,
   input  logic       Clear,
   input  logic       Count,
   output logic [6:0] Q
);

   logic [6:0] q_r;

   // Counter register: clear wins over count.
   always_ff @(posedge Clk) begin
      if (Clear) begin
         q_r <= 7'd0;
      end else if (Count) begin
         q_r <= q_r + 7'd1;
      end else begin
         q_r <= q_r;
      end
   end

   assign Q = q_r;

endmodule

// File: rtl/traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl
//   Two-road (NS/EW) traffic-light sequencer with pedestrian walk service.
//   Six-phase Moore FSM NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> NS_G,
//   each phase timed by phase_timer in Enable ticks. A pedestrian request
//   shortens the running green to T_GREEN_MIN and turns the next all-red
//   phase into a T_WALK-long walk interval.
//   Ports:
//     Clk      in   system clock, rising edge
//     Clear    in   synchronous active-high reset (overrides everything)
//     Enable   in   timing tick; state and timer advance only when 1
//     PedReq   in   pedestrian button, sampled every cycle
//     NS       out  {R,Y,G} lamps north-south (registered)
//     EW       out  {R,Y,G} lamps east-west (registered)
//     PedWalk  out  walk lamp (registered)
//     Phase    out  current state encoding, debug
// ----------------------------------------------------------------------------
module traffic_light_ctrl #(
   parameter int T_GREEN     = 100,
   parameter int T_GREEN_MIN = 30,
   parameter int T_YELLOW    = 20,
   parameter int T_ALLRED    = 5,
   parameter int T_WALK      = 60
) (
   input  logic       Clk,
   input  logic       Clear,
   input  logic       Enable,
   input  logic       PedReq,
   output logic [2:0] NS,
   output logic [2:0] EW,
   output logic       PedWalk,
   output logic [2:0] Phase
);

   import traffic_light_ctrl_pkg::*;

   // Last timer value of each phase: the phase ends on the edge seeing it.
   localparam logic [6:0] G_END    = 7'(T_GREEN - 1);
   localparam logic [6:0] GMIN_END = 7'(T_GREEN_MIN - 1);
   localparam logic [6:0] Y_END    = 7'(T_YELLOW - 1);
   localparam logic [6:0] AR_END   = 7'(T_ALLRED - 1);
   localparam logic [6:0] W_END    = 7'(T_WALK - 1);

   phase_e     state_r;
   phase_e     next_state_s;
   logic       pend_r;
   logic       pend_next_s;
   logic       walk_r;
   logic       walk_next_s;
   logic       phase_end_s;
   logic       timer_clr_s;
   logic [6:0] q_s;
   logic [2:0] ns_r;
   logic [2:0] ew_r;
   logic       pedwalk_r;

   // Leaving a phase restarts the timer so each phase counts from 0.
   assign timer_clr_s = Clear | phase_end_s;

   phase_timer u_timer (
      .Clk   (Clk),
      .Clear (timer_clr_s),
      .Count (Enable),
      .Q     (q_s)
   );

   // End-of-phase compare; illegal encodings recover without waiting for Enable.
   always_comb begin
      phase_end_s = 1'b0;
      case (state_r)
         NS_G, EW_G: phase_end_s = Enable & ((q_s == G_END) | (pend_r & (q_s >= GMIN_END)));
         NS_Y, EW_Y: phase_end_s = Enable & (q_s == Y_END);
         AR1, AR2:   phase_end_s = Enable & (q_s == (walk_r ? W_END : AR_END));
         default:    phase_end_s = 1'b1;
      endcase
   end

   // Next-state, walk and pending logic.
   always_comb begin
      next_state_s = state_r;
      walk_next_s  = walk_r;
      pend_next_s  = pend_r;
      if (phase_end_s) begin
         case (state_r)
            NS_G: begin
               next_state_s = NS_Y;
            end
            NS_Y: begin
               next_state_s = AR1;
               walk_next_s  = pend_r;
            end
            AR1: begin
               next_state_s = EW_G;
               walk_next_s  = 1'b0;
            end
            EW_G: begin
               next_state_s = EW_Y;
            end
            EW_Y: begin
               next_state_s = AR2;
               walk_next_s  = pend_r;
            end
            AR2: begin
               next_state_s = NS_G;
               walk_next_s  = 1'b0;
            end
            default: begin
               next_state_s = NS_G;
               walk_next_s  = 1'b0;
            end
         endcase
      end else begin
         next_state_s = state_r;
      end
      // A press on the edge entering all-red must survive to the next all-red.
      if (PedReq) begin
         pend_next_s = 1'b1;
      end else if (phase_end_s && ((state_r == NS_Y) || (state_r == EW_Y))) begin
         pend_next_s = 1'b0;
      end else begin
         pend_next_s = pend_r;
      end
   end

   // State, request and output registers; lamps decoded from the next state.
   always_ff @(posedge Clk) begin
      if (Clear) begin
         state_r   <= NS_G;
         pend_r    <= 1'b0;
         walk_r    <= 1'b0;
         ns_r      <= LAMP_G;
         ew_r      <= LAMP_R;
         pedwalk_r <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         pend_r    <= pend_next_s;
         walk_r    <= walk_next_s;
         ns_r      <= ns_lamp(next_state_s);
         ew_r      <= ew_lamp(next_state_s);
         pedwalk_r <= walk_next_s & is_allred(next_state_s);
      end
   end

   assign NS      = ns_r;
   assign EW      = ew_r;
   assign PedWalk = pedwalk_r;
   assign Phase   = state_r;

endmodule
